// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet MAC: GMII constants, TX FSM states
// and a byte-wise reflected CRC-32 update (poly 0x04C11DB7, LSB first).
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } tx_state_t;

  function automatic logic [31:0] crc32_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ ETH_CRC_POLY)
                        : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_eth.sv
// Registered Ethernet CRC-32 (init all-ones, no final invert on crc_out).
// Ports: clk, rst_n, clear, enable, data_in[7:0] -> crc_out[31:0].
module crc32_eth
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] r_crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '1;
    end else if (clear) begin
      r_crc <= '1;
    end else if (enable) begin
      r_crc <= crc32_byte(r_crc, data_in);
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/eth_mac_tx.sv
// GMII transmit MAC: preamble/SFD, payload, zero pad, FCS, inter-frame gap.
// In: clk, rst_n, tx_data/valid/sof/eof. Out: tx_ready, gmii_*, tx_busy, tx_abort.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_LEN      = 12,
  parameter bit PAD_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_sof,
  input  logic       tx_eof,
  output logic       tx_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_busy,
  output logic       tx_abort
);

  tx_state_t   r_state;
  logic [3:0]  r_phase;
  logic [15:0] r_byte_cnt;
  logic [31:0] r_fcs;

  logic [31:0] w_crc;
  logic [31:0] w_fcs;
  logic        w_start;
  logic        w_crc_en;
  logic [7:0]  w_crc_din;
  logic [16:0] w_cnt_inc;
  logic [15:0] w_cnt_sat;
  logic        w_short;

  assign w_start   = (r_state == S_IDLE) && tx_valid && tx_sof;
  assign w_crc_en  = ((r_state == S_DATA) && tx_valid)
                   || (r_state == S_PAD);
  assign w_crc_din = (r_state == S_DATA) ? tx_data : 8'h00;
  assign w_cnt_inc = {1'b0, r_byte_cnt} + 17'd1;
  assign w_cnt_sat = (&r_byte_cnt) ? r_byte_cnt
                                   : w_cnt_inc[15:0];
  assign w_short   = PAD_EN && (w_cnt_inc < 17'(MIN_FRAME));
  assign w_fcs     = ~w_crc;

  assign tx_ready = (r_state == S_DATA)
                 || ((r_state == S_IDLE) && tx_valid && !tx_sof);
  assign tx_busy  = (r_state != S_IDLE);

  // CRC sees exactly the byte loaded into gmii_txd on the same edge.
  crc32_eth u_crc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_start),
    .enable  (w_crc_en),
    .data_in (w_crc_din),
    .crc_out (w_crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_byte_cnt <= '0;
      r_fcs      <= '0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      tx_abort   <= 1'b0;
    end else begin
      gmii_tx_er <= 1'b0;
      tx_abort   <= 1'b0;
      gmii_tx_en <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (w_start) begin
            // first preamble byte leaves on this edge
            r_state    <= S_PRE;
            r_phase    <= 4'd1;
            r_byte_cnt <= '0;
            gmii_txd   <= ETH_PREAMBLE;
            gmii_tx_en <= 1'b1;
          end
        end
        S_PRE: begin
          gmii_txd <= ETH_PREAMBLE;
          r_phase  <= r_phase + 4'd1;
          if (r_phase == 4'(PREAMBLE_LEN - 1)) begin
            r_state <= S_SFD;
          end
        end
        S_SFD: begin
          gmii_txd <= ETH_SFD;
          r_state  <= S_DATA;
        end
        S_DATA: begin
          r_phase <= '0;
          if (tx_valid) begin
            gmii_txd   <= tx_data;
            r_byte_cnt <= w_cnt_sat;
            if (tx_eof) begin
              r_state <= w_short ? S_PAD : S_FCS;
            end
          end else begin
            // underrun: poison the frame and skip the FCS
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            tx_abort   <= 1'b1;
            r_state    <= S_IFG;
          end
        end
        S_PAD: begin
          gmii_txd   <= 8'h00;
          r_byte_cnt <= w_cnt_sat;
          if (w_cnt_inc == 17'(MIN_FRAME)) begin
            r_state <= S_FCS;
          end
        end
        S_FCS: begin
          r_phase <= r_phase + 4'd1;
          if (r_phase == 4'd0) begin
            gmii_txd <= w_fcs[7:0];
            r_fcs    <= w_fcs;
          end else begin
            gmii_txd <= r_fcs[{r_phase[1:0], 3'b000} +: 8];
          end
          if (r_phase == 4'd3) begin
            r_state <= S_IFG;
            r_phase <= '0;
          end
        end
        S_IFG: begin
          // IFG_LEN+1 idle edges so the wire gap matches
          // the registered launch of the next preamble
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (r_phase == 4'(IFG_LEN)) begin
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + 4'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          gmii_tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Bench for eth_mac_tx: DUT0 with PAD_EN=0, DUT1 with PAD_EN=1, same stimulus.
// Frames on GMII are captured and checked against a queue-based frame model.
module tb_eth_mac_tx;
  import eth_pkg::*;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_sof, tx_eof;
  logic [1:0] rdy, en, er, ab, busy;
  logic [7:0] txd0, txd1;

  eth_mac_tx #(.PAD_EN(1'b0)) u_np (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .tx_ready(rdy[0]), .gmii_txd(txd0), .gmii_tx_en(en[0]),
    .gmii_tx_er(er[0]), .tx_busy(busy[0]), .tx_abort(ab[0])
  );

  eth_mac_tx #(.PAD_EN(1'b1)) u_pd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .tx_ready(rdy[1]), .gmii_txd(txd1), .gmii_tx_en(en[1]),
    .gmii_tx_er(er[1]), .tx_busy(busy[1]), .tx_abort(ab[1])
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] crc_tbl [256];
  logic [31:0] res_ref;

  logic [7:0] pl_q[$], pl_a[$], exp_q[$], got_q[$];

  // monitor state
  logic [7:0] cap_b [2][$];
  int cap_l [2][$];
  int gap_q [2][$];
  int cur_n [2];
  int idle_n [2];
  int er_n [2];
  int ab_n [2];
  bit prev_en [2];
  bit seen [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      cur_n[d] = 0; idle_n[d] = 0; er_n[d] = 0;
      ab_n[d] = 0; prev_en[d] = 0; seen[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          repeat (cur_n[d]) void'(cap_b[d].pop_back());
          cur_n[d] = 0; prev_en[d] = 0;
          seen[d] = 0; idle_n[d] = 0;
        end else begin
          if (er[d]) er_n[d]++;
          if (ab[d]) ab_n[d]++;
          if (en[d]) begin
            if (!prev_en[d] && seen[d])
              gap_q[d].push_back(idle_n[d]);
            cap_b[d].push_back(d ? txd1 : txd0);
            cur_n[d]++;
          end else begin
            if (prev_en[d]) begin
              cap_l[d].push_back(cur_n[d]);
              cur_n[d] = 0; seen[d] = 1; idle_n[d] = 0;
            end
            idle_n[d]++;
          end
          prev_en[d] = en[d];
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_q(
    input logic [7:0] q[$], input int from);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = from; i < q.size(); i++)
      c = crc_tbl[c[7:0] ^ q[i]] ^ (c >> 8);
    return c;
  endfunction

  // Frame model: wire image of a good frame for one PAD_EN setting
  task automatic build_exp(input bit pad);
    logic [7:0] body[$];
    logic [31:0] f;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (pl_q[i]) body.push_back(pl_q[i]);
    if (pad) while (body.size() < 60) body.push_back(8'h00);
    f = ~crc_q(body, 0);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
  endtask

  task automatic build_abort(input int n);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n; i++) exp_q.push_back(pl_q[i]);
    exp_q.push_back(8'h00);
  endtask

  task automatic fill(input int len, input int kind);
    string s;
    s = "123456789";
    pl_q.delete();
    for (int i = 0; i < len; i++) begin
      if (kind == 1) pl_q.push_back(s[i % 9]);
      else if (kind == 2) pl_q.push_back(8'hAA);
      else pl_q.push_back(8'($urandom));
    end
  endtask

  task automatic idle_in();
    tx_valid = 1'b0; tx_sof = 1'b0;
    tx_eof = 1'b0; tx_data = 8'h00;
  endtask

  task automatic send_frame(input int drop_at);
    int i, guard;
    bit acc;
    i = 0; guard = 0;
    while (i < pl_q.size()) begin
      if (i == drop_at) begin
        idle_in();
        @(posedge clk); #1;
        break;
      end
      tx_valid = 1'b1;
      tx_data  = pl_q[i];
      tx_sof   = (i == 0);
      tx_eof   = (i == pl_q.size() - 1);
      @(negedge clk);
      acc = rdy[1];
      @(posedge clk); #1;
      if (acc) begin
        i++;
        guard = 0;
      end else if (++guard > 200) begin
        tests++; fails++;
        $display("FAIL send: no tx_ready in 200 cycles at byte %0d", i);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (busy == 2'b00) break;
      n++;
    end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy=%b after 3000 cycles, required 00",
               busy);
    end
  endtask

  task automatic check_frame(input int d, input string nm,
                             input int en_exp, input bit lb);
    int n, bad;
    logic [7:0] act;
    got_q.delete();
    tests++;
    if (cap_l[d].size() == 0) begin
      fails++;
      $display("FAIL %s dut%0d: no frame, required %0d bytes",
               nm, d, exp_q.size());
    end else begin
      n = cap_l[d].pop_front();
      for (int i = 0; i < n; i++) got_q.push_back(cap_b[d].pop_front());
      bad = -1; act = 8'h00;
      for (int i = 0; i < n; i++) begin
        if (bad < 0 && (i >= exp_q.size() || got_q[i] !== exp_q[i])) begin
          bad = i; act = got_q[i];
        end
      end
      if (n != exp_q.size() || bad >= 0) begin
        fails++;
        $display("FAIL %s dut%0d: len %0d byte[%0d]=%02h, required len %0d byte=%02h",
                 nm, d, n, bad, act, exp_q.size(),
                 (bad >= 0 && bad < exp_q.size()) ? exp_q[bad] : 8'h00);
      end
    end
    if (en_exp >= 0) begin
      tests++;
      if (got_q.size() != en_exp) begin
        fails++;
        $display("FAIL %s dut%0d tx_en cycles: got %0d, required %0d",
                 nm, d, got_q.size(), en_exp);
      end
    end
    if (lb) begin
      bit ok;
      ok = (got_q.size() >= 12);
      for (int i = 0; i < 8 && ok; i++)
        if (got_q[i] !== ((i < 7) ? 8'h55 : 8'hD5)) ok = 0;
      if (ok && crc_q(got_q, 8) !== res_ref) ok = 0;
      if (ok && d == 1 && got_q.size() < 72) ok = 0;
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL %s dut%0d loopback: rx_error=1, required 0", nm, d);
      end
    end
  endtask

  typedef struct {
    int          len;
    int          kind;
    int          en_np;
    int          en_pd;
    bit          chk_fcs;
    logic [31:0] fcs_np;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] c, r;
    int gp;
    bit ok;

    vt[0] = '{9,    1, 21,   72,   1'b1, 32'hCBF43926};
    vt[1] = '{1,    2, 13,   72,   1'b0, 32'h0};
    vt[2] = '{59,   0, 71,   72,   1'b0, 32'h0};
    vt[3] = '{60,   0, 72,   72,   1'b0, 32'h0};
    vt[4] = '{61,   0, 73,   73,   1'b0, 32'h0};
    vt[5] = '{1500, 0, 1512, 1512, 1'b0, 32'h0};

    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[n] = c;
    end
    r = ETH_CRC_RESIDUE;
    for (int i = 0; i < 32; i++) res_ref[i] = r[31-i];

    rst_n = 1'b0;
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (en[d] !== 1'b0 || er[d] !== 1'b0 || ab[d] !== 1'b0
          || busy[d] !== 1'b0 || (d ? txd1 : txd0) !== 8'h00) begin
        fails++;
        $display("FAIL reset dut%0d: en=%b er=%b ab=%b busy=%b, required 0",
                 d, en[d], er[d], ab[d], busy[d]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // directed vector table
    foreach (vt[v]) begin
      fill(vt[v].len, vt[v].kind);
      send_frame(-1);
      idle_in();
      wait_idle();
      build_exp(1'b0);
      check_frame(0, $sformatf("vec%0d", v), vt[v].en_np, 1'b1);
      if (vt[v].chk_fcs) begin
        tests++;
        if (got_q.size() < 4 ||
            {got_q[got_q.size()-1], got_q[got_q.size()-2],
             got_q[got_q.size()-3], got_q[got_q.size()-4]}
            !== vt[v].fcs_np) begin
          fails++;
          $display("FAIL vec%0d fcs: wrong bytes, required %08h",
                   v, vt[v].fcs_np);
        end
      end
      build_exp(1'b1);
      check_frame(1, $sformatf("vec%0d", v), vt[v].en_pd, 1'b1);
    end

    // back-to-back with sof held waiting through the gap
    fill(70, 0);
    pl_a = pl_q;
    send_frame(-1);
    fill(70, 0);
    send_frame(-1);
    idle_in();
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] keep[$];
      keep = pl_q;
      pl_q = pl_a;
      build_exp(d == 1);
      check_frame(d, "b2b_f1", 82, 1'b1);
      pl_q = keep;
      build_exp(d == 1);
      check_frame(d, "b2b_f2", 82, 1'b1);
      gp = (gap_q[d].size() > 0) ? gap_q[d][$] : -1;
      tests++;
      if (gp != 13) begin
        fails++;
        $display("FAIL b2b gap dut%0d: got %0d idle cycles, required 13",
                 d, gp);
      end
    end

    // underrun at payload byte 10
    er_n[0] = 0; er_n[1] = 0; ab_n[0] = 0; ab_n[1] = 0;
    fill(80, 0);
    send_frame(10);
    idle_in();
    wait_idle();
    build_abort(10);
    for (int d = 0; d < 2; d++) begin
      check_frame(d, "underrun", 19, 1'b0);
      tests++;
      if (er_n[d] != 1 || ab_n[d] != 1) begin
        fails++;
        $display("FAIL underrun dut%0d: er=%0d abort=%0d, required 1 1",
                 d, er_n[d], ab_n[d]);
      end
    end

    // reset during FCS, then stray bytes, then a clean frame
    fill(64, 0);
    send_frame(-1);
    idle_in();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (en !== 2'b00 || busy !== 2'b00) begin
      fails++;
      $display("FAIL rst_fcs: en=%b busy=%b, required 00 00", en, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tx_valid = 1'b1;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'(8'hF0 + i);
      @(negedge clk);
      if (rdy !== 2'b11 || busy !== 2'b00 || en !== 2'b00) ok = 0;
      @(posedge clk);
      #1;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stray: rdy=%b busy=%b en=%b, required 11 00 00",
               rdy, busy, en);
    end
    fill(25, 0);
    send_frame(-1);
    idle_in();
    wait_idle();
    build_exp(1'b0);
    check_frame(0, "post_rst", 37, 1'b1);
    build_exp(1'b1);
    check_frame(1, "post_rst", 72, 1'b1);

    // randomized frames
    for (int t = 0; t < 10; t++) begin
      int len;
      len = $urandom_range(1, 200);
      fill(len, 0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      send_frame(-1);
      idle_in();
      wait_idle();
      build_exp(1'b0);
      check_frame(0, $sformatf("rand%0d", t), -1, 1'b1);
      build_exp(1'b1);
      check_frame(1, $sformatf("rand%0d", t), -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
